// File: rtl/fsm_stream_pkg.sv
// Shared types and helpers for the serial stream path feeding the sequence detector.
package fsm_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  localparam logic DEF_IDLE_BIT = 1'b0;

  // Never returns less than 1, so a degenerate count still yields a legal vector.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period divider: one-cycle tick on the terminal count, realigned by clr.
module bit_tick_gen
  import fsm_stream_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = clog2(DIV);
  localparam logic [CW-1:0] TERM = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // With DIV=1 the counter sits at 0 == TERM, so tick is held high.
  always_ff @(posedge clk) begin
    if (rst || clr || tick) cnt <= '0;
    else                    cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == TERM);

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial source for the sequence detector: MSB first, DIV clocks per bit,
// optional GAP idle bit-periods after each word.
module bit_serializer
  import fsm_stream_pkg::*;
#(
  parameter int   WIDTH    = 8,
  parameter int   DIV      = 1,
  parameter int   GAP      = 0,
  parameter logic IDLE_BIT = DEF_IDLE_BIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             data,
  output logic             busy,
  output logic             frame_done
);

  localparam int            BW       = clog2(WIDTH);
  localparam int            GAP_CYC  = GAP * DIV;
  localparam int            GW       = clog2(GAP_CYC + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = (GAP_CYC > 0) ? GW'(GAP_CYC - 1) : '0;

  state_e           state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic [GW-1:0]    gap_cnt;
  logic             tick;
  logic             accept;
  logic             last_bit;

  assign din_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign accept    = din_valid && din_ready;
  assign last_bit  = (bit_cnt == LAST_BIT);

  bit_tick_gen #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst_n),
    .clr  (accept),
    .tick (tick)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_SHIFT;
      ST_SHIFT: if (tick && last_bit) state_nxt = (GAP > 0) ? ST_GAP : ST_IDLE;
      ST_GAP:   if (gap_cnt == GAP_LAST) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      data       <= IDLE_BIT;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            shreg   <= din;
            data    <= din[WIDTH-1];
            bit_cnt <= '0;
          end
        end
        ST_SHIFT: begin
          if (tick) begin
            if (last_bit) begin
              data       <= IDLE_BIT;
              frame_done <= 1'b1;
              bit_cnt    <= '0;
              gap_cnt    <= '0;
            end else begin
              // shreg[WIDTH-1] is the bit on the wire now; the next one sits below it.
              shreg   <= shreg << 1;
              data    <= shreg[WIDTH-2];
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        ST_GAP: begin
          data <= IDLE_BIT;
          if (gap_cnt == GAP_LAST) gap_cnt <= '0;
          else                     gap_cnt <= gap_cnt + 1'b1;
        end
        default: data <= IDLE_BIT;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed + random bench over four parameterisations of bit_serializer.
module tb_bit_serializer;

  localparam int   NU = 4;
  localparam int   DIVS  [NU] = '{1, 3, 1, 3};
  localparam int   GAPS  [NU] = '{0, 0, 2, 1};
  localparam logic IDLES [NU] = '{1'b0, 1'b0, 1'b1, 1'b0};

  logic       clk;
  logic       rst [NU];
  logic       vld [NU];
  logic [7:0] din [NU];
  logic       rdy [NU];
  logic       dat [NU];
  logic       bsy [NU];
  logic       fd  [NU];

  int tests = 0;
  int fails = 0;

  for (genvar g = 0; g < NU; g++) begin : g_dut
    bit_serializer #(
      .WIDTH    (8),
      .DIV      (DIVS[g]),
      .GAP      (GAPS[g]),
      .IDLE_BIT (IDLES[g])
    ) dut (
      .clk        (clk),
      .rst_n      (rst[g]),
      .din        (din[g]),
      .din_valid  (vld[g]),
      .din_ready  (rdy[g]),
      .data       (dat[g]),
      .busy       (bsy[g]),
      .frame_done (fd[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int u, input logic obs, input logic expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s u%0d t=%0t obs=%b exp=%b", tag, u, $time, obs, expv);
    end
  endtask

  // Reference: word accepted at edge E0; sampled #1 after each later edge, cycle c.
  // poke: pulse din_valid with 8'h3C mid-word. keep: hold valid with nxt queued.
  task automatic run_word(input int u, input logic [7:0] w, input bit poke,
                          input bit keep, input logic [7:0] nxt);
    int d, gp, last;
    logic ed, eb, er, ef, ib;
    d    = DIVS[u];
    gp   = GAPS[u];
    ib   = IDLES[u];
    last = (8 + gp) * d;
    chk("pre_ready", u, rdy[u], 1'b1);
    din[u] = w;
    vld[u] = 1'b1;
    @(posedge clk); #1;
    if (keep) din[u] = nxt;
    else begin
      vld[u] = 1'b0;
      din[u] = 8'($urandom);
    end
    for (int c = 0; c <= last; c++) begin
      if (c < 8 * d) begin
        ed = w[7 - c / d]; eb = 1'b1; er = 1'b0; ef = 1'b0;
      end else if (c == 8 * d) begin
        ed = ib; ef = 1'b1; eb = (gp > 0); er = (gp == 0);
      end else if (c < last) begin
        ed = ib; eb = 1'b1; er = 1'b0; ef = 1'b0;
      end else begin
        ed = ib; eb = 1'b0; er = 1'b1; ef = 1'b0;
      end
      chk("data", u, dat[u], ed);
      chk("busy", u, bsy[u], eb);
      chk("ready", u, rdy[u], er);
      chk("frame_done", u, fd[u], ef);
      if (poke && c == 2) begin din[u] = 8'h3C; vld[u] = 1'b1; end
      if (poke && c == 3) vld[u] = 1'b0;
      if (c < last) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    logic [7:0] w, nw;
    bit kp;
    for (int u = 0; u < NU; u++) begin
      rst[u] = 1'b1; vld[u] = 1'b1; din[u] = 8'hFF;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < NU; u++) begin
      chk("rst_data", u, dat[u], IDLES[u]);
      chk("rst_ready", u, rdy[u], 1'b1);
      chk("rst_busy", u, bsy[u], 1'b0);
      chk("rst_fd", u, fd[u], 1'b0);
      rst[u] = 1'b0; vld[u] = 1'b0;
    end

    // DIV=1, GAP=0
    run_word(0, 8'hB2, 1'b0, 1'b0, 8'h00);
    run_word(0, 8'h5A, 1'b1, 1'b0, 8'h00);

    // Reset in cycle 4 of a word drops it; no frame_done afterwards.
    din[0] = 8'hFF; vld[0] = 1'b1;
    @(posedge clk); #1;
    vld[0] = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("mid_data_before", 0, dat[0], 1'b1);
    rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    chk("mid_rst_data", 0, dat[0], 1'b0);
    chk("mid_rst_ready", 0, rdy[0], 1'b1);
    chk("mid_rst_busy", 0, bsy[0], 1'b0);
    chk("mid_rst_fd", 0, fd[0], 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("post_rst_fd", 0, fd[0], 1'b0);
      chk("post_rst_data", 0, dat[0], 1'b0);
    end
    run_word(0, 8'h81, 1'b0, 1'b0, 8'h00);

    // DIV=3 and GAP directed words, incl. valid held high back to back.
    run_word(1, 8'hA5, 1'b1, 1'b0, 8'h00);
    run_word(2, 8'hFF, 1'b0, 1'b1, 8'h00);
    run_word(2, 8'h00, 1'b0, 1'b0, 8'h00);
    run_word(3, 8'hC3, 1'b0, 1'b1, 8'h3C);
    run_word(3, 8'h3C, 1'b1, 1'b0, 8'h00);

    // Random words on every configuration.
    for (int u = 0; u < NU; u++) begin
      w = 8'($urandom);
      for (int i = 0; i < 8; i++) begin
        nw = 8'($urandom);
        kp = (i < 7) && ($urandom_range(0, 1) == 1);
        run_word(u, w, !kp && ($urandom_range(0, 1) == 1), kp, nw);
        w = nw;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
- Upstream stage for the serial sequence detector (fsm_moore). Converts parallel words, accepted over a valid/ready handshake, into the single-bit `data` stream the detector samples every clk.
- Shifts MSB first. Holds each bit for DIV clocks and inserts an optional idle gap between words.
- Gives the team a deterministic, pattern-controlled stimulus/source for the detector in place of random bits.

Parameters:
- WIDTH, 8: word width in bits. Must be 2 or more.
- DIV, 1: clk cycles per serial bit. Must be 1 or more.
- GAP, 0: idle bit-periods inserted after each word. Must be 0 or more.
- IDLE_BIT, 1'b0: level driven on `data` when no word bit is being sent.

Ports:
- clk, in, 1: single clock. Everything samples on the rising edge.
- rst_n, in, 1: synchronous, active-high reset. The name is kept per codebase; polarity is fixed high.
- din, in, WIDTH: parallel word.
- din_valid, in, 1: din holds a word to send.
- din_ready, out, 1: block can accept a word this cycle.
- data, out, 1: registered serial bit to the downstream detector.
- busy, out, 1: a word or gap is in progress.
- frame_done, out, 1: one-cycle pulse after the last bit period of a word ends.

Behaviour:
- States: ST_IDLE, ST_SHIFT, ST_GAP. Encoding comes from the package.
- Reset (rst_n=1 at a clk edge), including mid-word:
  - state = ST_IDLE, data = IDLE_BIT, frame_done = 0.
  - shift register, bit counter and div counter cleared.
  - The word in flight is dropped; nothing is resumed.
- din_ready = (state == ST_IDLE), decoded combinationally from state. busy = (state != ST_IDLE).
- Handshake:
  - A word is accepted at an edge where din_valid && din_ready.
  - In that same edge: shift register loads din, data becomes din[WIDTH-1], bit counter = 0, div counter = 0, state goes to ST_SHIFT.
  - din_valid while din_ready=0 is ignored. din may change freely when not accepted. No buffering.
- ST_SHIFT:
  - div counter counts 0..DIV-1 and wraps. Each wrap advances to the next bit: shift left, data gets the new MSB, bit counter increments.
  - At the wrap of bit index WIDTH-1:
    - data goes to IDLE_BIT and frame_done is set to 1 for exactly one cycle.
    - state goes to ST_GAP if GAP>0, otherwise to ST_IDLE.
- ST_GAP:
  - data stays at IDLE_BIT for GAP*DIV cycles, then state goes to ST_IDLE.
  - The gap counter width is clog2(GAP*DIV+1).
- Latency:
  - Bit k of the word (k = WIDTH-1 down to 0) is driven during cycles (WIDTH-1-k)*DIV .. (WIDTH-k)*DIV-1 after the accept edge. Cycle 0 is the cycle right after that edge.
  - frame_done and the next ST_IDLE/ST_GAP entry fall in cycle WIDTH*DIV.
- Throughput: the minimum word period is (WIDTH+GAP)*DIV+1 cycles. ST_IDLE always lasts at least 1 cycle.
- Counters wrap only at their defined terminal values. No arithmetic overflow is possible for legal parameters.
- frame_done and a new accept never coincide, because accept requires ST_IDLE.

Decomposition:
- Shared package fsm_stream_pkg holds:
  - state localparams ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_GAP=2'd2;
  - a clog2 constant function;
  - the default IDLE_BIT.
- One natural sub-module, bit_tick_gen (parameter DIV):
  - a free-running divide counter with a sync clear on accept;
  - outputs a one-cycle `tick` on the terminal count;
  - with DIV=1, tick is constant 1.
- Target size: about 150–200 RTL lines in total.

Test Plan:
- WIDTH=8, DIV=1, GAP=0, din=8'hB2 accepted at edge E0 -> data = 1,0,1,1,0,0,1,0 in cycles 0..7; frame_done=1 only in cycle 8; din_ready back to 1 in cycle 8; data=0 in cycle 8.
- DIV=3: din=8'hA5 -> each bit held exactly 3 cycles (24 cycles total); frame_done in cycle 24; busy=1 in cycles 0..23.
- GAP=2, DIV=1, din_valid held high with words 8'hFF then 8'h00 -> 8 ones, 2 cycles at IDLE_BIT, 1 IDLE cycle, then 8 zeros; second accept occurs 11 cycles after the first.
- rst_n asserted in cycle 4 of a word (DIV=1) -> next cycle data=IDLE_BIT, din_ready=1, busy=0, frame_done never pulses for that word.
- din_valid pulsed while busy=1 with din=8'h3C -> ignored; the output stream of the current word is unchanged and no extra frame is sent.
- End to end: serializer drives fsm_moore.data with a word containing the detector's target pattern -> detector `out` asserts at the cycle predicted by the bit timing; a word without the pattern -> out stays 0.
